step_sequencer: RTL and testbench

//  Transmit-side partner of the receive step counter in the matrix/vector datapath.
//  On start, it walks a vector of len elements in beats of up to STEP elements.

---
 rtl/step_sequencer.sv | 135 +++++++++++++
 tb/tb_step_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/step_sequencer.sv
// Transmit-side beat sequencer: walks a vector of len elements in beats of up
// to STEP elements, one beat per valid/ready handshake, flagging the final beat.
module step_sequencer #(
  parameter int unsigned COUNTER_WIDTH = 11,
  parameter int unsigned STEP          = 6,
  parameter int unsigned CNT_WIDTH     = 3
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic [COUNTER_WIDTH-1:0] len,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [COUNTER_WIDTH-1:0] out_offset,
  output logic [CNT_WIDTH-1:0]     out_count,
  output logic                     out_last,
  output logic                     done
);

  // One extra bit so offset+STEP style sums cannot wrap.
  localparam int unsigned W1 = COUNTER_WIDTH + 1;
  localparam logic [W1-1:0] STEP_W = W1'(STEP);
  localparam logic [CNT_WIDTH-1:0] STEP_C = CNT_WIDTH'(STEP);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                   r_state;
  logic [COUNTER_WIDTH-1:0] r_len;
  logic [COUNTER_WIDTH-1:0] r_offset;
  logic [CNT_WIDTH-1:0]     r_count;
  logic                     r_valid;
  logic                     r_last;
  logic                     r_busy;
  logic                     r_done;

  logic [W1-1:0]        w_start_len;
  logic [W1-1:0]        w_q_len;
  logic [W1-1:0]        w_nxt_off;
  logic [W1-1:0]        w_nxt_rem;
  logic [W1-1:0]        w_nxt_end;
  logic [CNT_WIDTH-1:0] w_nxt_cnt;
  logic [CNT_WIDTH-1:0] w_st_cnt;
  logic                 w_nxt_last;
  logic                 w_st_last;
  logic                 w_fire;

  // Beat descriptors for the first beat (from len) and the following beat (from r_offset).
  always_comb begin
    w_start_len = {1'b0, len};
    w_q_len     = {1'b0, r_len};
    w_nxt_off   = {1'b0, r_offset} + STEP_W;
    w_nxt_rem   = w_q_len - w_nxt_off;
    w_nxt_end   = w_nxt_off + STEP_W;
    w_nxt_cnt   = (w_nxt_rem >= STEP_W) ? STEP_C : CNT_WIDTH'(w_nxt_rem);
    w_nxt_last  = (w_nxt_end >= w_q_len);
    w_st_cnt    = (w_start_len >= STEP_W) ? STEP_C : CNT_WIDTH'(w_start_len);
    w_st_last   = (STEP_W >= w_start_len);
    w_fire      = r_valid & out_ready;
  end

  // Sequencer FSM with registered beat outputs; beat fields hold while stalled.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_len    <= '0;
      r_offset <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            if (len != '0) begin
              r_state  <= S_RUN;
              r_len    <= len;
              r_offset <= '0;
              r_count  <= w_st_cnt;
              r_last   <= w_st_last;
              r_valid  <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_fire) begin
            if (r_last) begin
              r_state  <= S_DONE;
              r_valid  <= 1'b0;
              r_offset <= '0;
              r_count  <= '0;
              r_last   <= 1'b0;
              r_done   <= 1'b1;
            end else begin
              r_offset <= w_nxt_off[COUNTER_WIDTH-1:0];
              r_count  <= w_nxt_cnt;
              r_last   <= w_nxt_last;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state  <= S_IDLE;
          r_valid  <= 1'b0;
          r_offset <= '0;
          r_count  <= '0;
          r_last   <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign out_valid  = r_valid;
  assign out_offset = r_offset;
  assign out_count  = r_count;
  assign out_last   = r_last;
  assign done       = r_done;

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer (COUNTER_WIDTH=11, STEP=6, CNT_WIDTH=3).
module tb_step_sequencer;

  localparam int unsigned CW = 11;
  localparam int unsigned ST = 6;
  localparam int unsigned NW = 3;

  logic          clk;
  logic          rstn;
  logic          start;
  logic [CW-1:0] len;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_offset;
  logic [NW-1:0] out_count;
  logic          out_last;
  logic          done;

  int checks = 0;
  int errors = 0;

  step_sequencer #(.COUNTER_WIDTH(CW), .STEP(ST), .CNT_WIDTH(NW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .len        (len),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_offset (out_offset),
    .out_count  (out_count),
    .out_last   (out_last),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"},  32'(out_valid),  32'd0);
    chk({tag, "_offset"}, 32'(out_offset), 32'd0);
    chk({tag, "_count"},  32'(out_count),  32'd0);
    chk({tag, "_last"},   32'(out_last),   32'd0);
    chk({tag, "_busy"},   32'(busy),       32'd0);
    chk({tag, "_done"},   32'(done),       32'd0);
  endtask

  task automatic chk_beat(input string tag, input int off, input int cnt, input int last);
    chk({tag, "_valid"},  32'(out_valid),  32'd1);
    chk({tag, "_offset"}, 32'(out_offset), 32'(off));
    chk({tag, "_count"},  32'(out_count),  32'(cnt));
    chk({tag, "_last"},   32'(out_last),   32'(last));
    chk({tag, "_busy"},   32'(busy),       32'd1);
    chk({tag, "_done"},   32'(done),       32'd0);
  endtask

  // Issue one transfer; inputs change on negedge, outputs are sampled on negedge.
  task automatic run_xfer(input int l, input bit rnd, output int beats, output int sum,
                          output int loff, output int lcnt);
    bit fin;
    int exp_off;
    int exp_cnt;
    beats = 0; sum = 0; loff = -1; lcnt = -1; fin = 1'b0;
    start = 1'b1; len = CW'(l); out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    len   = CW'($urandom);
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      if (done) begin
        fin = 1'b1;
      end else begin
        exp_off = beats * ST;
        exp_cnt = (l - exp_off < ST) ? (l - exp_off) : ST;
        chk_beat($sformatf("x%0d_b%0d", l, beats), exp_off, exp_cnt, (exp_off + ST >= l) ? 1 : 0);
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        start = 1'b1;
        if (out_valid && out_ready) begin
          beats++;
          sum += int'(out_count);
          loff = int'(out_offset);
          lcnt = int'(out_count);
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    out_ready = 1'b0;
    if (!fin) begin
      chk($sformatf("x%0d_timeout", l), 32'd0, 32'd1);
    end else begin
      chk($sformatf("x%0d_done_busy", l),  32'(busy),      32'd1);
      chk($sformatf("x%0d_done_valid", l), 32'(out_valid), 32'd0);
      @(negedge clk);
      chk_idle($sformatf("x%0d_after", l));
    end
  endtask

  int beats, sum, loff, lcnt;

  initial begin
    rstn = 1'b0; start = 1'b0; len = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle("reset");
    rstn = 1'b1;
    @(negedge clk);
    chk_idle("idle");

    // len=12, always ready: two back-to-back beats then done
    start = 1'b1; len = 11'd12; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; len = 11'd0;
    chk_beat("t1_b0", 0, 6, 0);
    @(negedge clk);
    chk_beat("t1_b1", 6, 6, 1);
    @(negedge clk);
    chk("t1_done",  32'(done),      32'd1);
    chk("t1_busy",  32'(busy),      32'd1);
    chk("t1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk_idle("t1_after");
    out_ready = 1'b0;

    // len=13: partial final beat
    run_xfer(13, 1'b0, beats, sum, loff, lcnt);
    chk("t2_beats", 32'(beats), 32'd3);
    chk("t2_sum",   32'(sum),   32'd13);
    chk("t2_loff",  32'(loff),  32'd12);
    chk("t2_lcnt",  32'(lcnt),  32'd1);

    // len=0: straight to done, no beats
    run_xfer(0, 1'b0, beats, sum, loff, lcnt);
    chk("t3_beats", 32'(beats), 32'd0);
    chk("t3_sum",   32'(sum),   32'd0);

    // len=12 with random backpressure
    run_xfer(12, 1'b1, beats, sum, loff, lcnt);
    chk("t4_beats", 32'(beats), 32'd2);
    chk("t4_sum",   32'(sum),   32'd12);
    chk("t4_loff",  32'(loff),  32'd6);
    chk("t4_lcnt",  32'(lcnt),  32'd6);

    // maximum len: no offset wrap
    run_xfer(2047, 1'b0, beats, sum, loff, lcnt);
    chk("t5_beats", 32'(beats), 32'd342);
    chk("t5_sum",   32'(sum),   32'd2047);
    chk("t5_loff",  32'(loff),  32'd2046);
    chk("t5_lcnt",  32'(lcnt),  32'd1);

    // reset during beat 2 of len=30
    start = 1'b1; len = 11'd30; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk_beat("t6_b0", 0, 6, 0);
    @(negedge clk);
    chk_beat("t6_b1", 6, 6, 0);
    rstn = 1'b0;
    @(negedge clk);
    chk_idle("t6_rst");
    rstn = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_idle($sformatf("t6_quiet%0d", i));
    end
    run_xfer(6, 1'b0, beats, sum, loff, lcnt);
    chk("t6_beats", 32'(beats), 32'd1);
    chk("t6_sum",   32'(sum),   32'd6);
    chk("t6_loff",  32'(loff),  32'd0);
    chk("t6_lcnt",  32'(lcnt),  32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
